// File: rtl/fetch_responder_if.sv
// ============================================================================
// fetch_responder_if : load, fetch-request and fetch-response signal bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_responder_if #(
  parameter int MEM_AW = 8
);
  logic              ld_en;
  logic [MEM_AW-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              ld_err;
  logic              req_valid;
  logic [31:0]       req_addr;
  logic              req_ready;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_fault;

  modport master (
    output ld_en, ld_addr, ld_data, req_valid, req_addr, flush, rsp_ready,
    input  ld_err, req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, req_valid, req_addr, flush, rsp_ready,
    output ld_err, req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

`default_nettype wire

// File: rtl/fetch_responder.sv
// ============================================================================
// fetch_responder : instruction-memory fetch responder, any byte alignment
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_responder #(
  parameter int MEM_AW  = 8,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_responder_if.slave   bus
);

  localparam int         c_DEPTH  = 1 << MEM_AW;
  localparam logic [2:0] c_LAT_M1 = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_fault;
  logic        r_ld_err;
  logic [31:0] r_mem [c_DEPTH];

  logic              w_req_ready;
  logic              w_accept;
  logic              w_req_span;
  logic [2:0]        w_wait_n;
  logic [MEM_AW-1:0] w_fidx;
  logic [31:0]       w_fword;
  logic              w_ffault;
  logic [MEM_AW-1:0] w_idx0;
  logic [MEM_AW-1:0] w_idx1;
  logic [55:0]       w_win;
  logic [31:0]       w_data;
  logic              w_fault;

  assign w_req_ready = (r_state == S_IDLE) && !bus.flush && !rst;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_req_span  = |bus.req_addr[1:0];
  assign w_wait_n    = c_LAT_M1 + {2'b00, w_req_span};

  // Zero-wait path (LATENCY 1, aligned): forward a same-cycle load so the write lands first
  assign w_fidx   = bus.req_addr[MEM_AW+1:2];
  assign w_fword  = (bus.ld_en && (bus.ld_addr == w_fidx)) ? bus.ld_data : r_mem[w_fidx];
  assign w_ffault = |bus.req_addr[31:MEM_AW+2];

  assign w_idx0  = r_addr[MEM_AW+1:2];
  assign w_idx1  = w_idx0 + MEM_AW'(1);
  assign w_win   = {r_mem[w_idx1][23:0], r_mem[w_idx0]};
  assign w_fault = (|r_addr[31:MEM_AW+2]) || ((|r_addr[1:0]) && (&w_idx0));

  always_comb begin
    w_data = w_win[31:0];
    case (r_addr[1:0])
      2'd1:    w_data = w_win[39:8];
      2'd2:    w_data = w_win[47:16];
      2'd3:    w_data = w_win[55:24];
      default: w_data = w_win[31:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_addr      <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_fault <= 1'b0;
      r_ld_err    <= 1'b0;
    end else begin
      r_ld_err <= bus.ld_en && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= bus.req_addr;
            if (w_wait_n == 3'd0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= w_ffault;
              r_rsp_data  <= w_ffault ? 32'd0 : w_fword;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= w_wait_n - 3'd1;
            end
          end
        end
        S_WAIT: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else if (r_cnt == 3'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= w_fault;
            r_rsp_data  <= w_fault ? 32'd0 : w_data;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (bus.flush || bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_fault <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (!rst && bus.ld_en && (r_state == S_IDLE)) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.ld_err    = r_ld_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_responder.sv
// ============================================================================
// tb_fetch_responder : randomized scoreboard bench for fetch_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_responder;
  localparam int MEM_AW = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_responder_if #(.MEM_AW(MEM_AW)) bus();

  fetch_responder #(.MEM_AW(MEM_AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] model [DEPTH];

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte-by-byte view of memory: any byte beyond the last word faults
  function automatic exp_t predict(input logic [31:0] a);
    exp_t        e;
    logic [63:0] b;
    logic [31:0] w;
    e.data  = '0;
    e.fault = 1'b0;
    e.due   = 0;
    for (int i = 0; i < 4; i++) begin
      b = {32'd0, a} + 64'(i);
      if (b >= 64'(4 * DEPTH)) e.fault = 1'b1;
      else begin
        w = model[int'(b / 4)];
        e.data[8*i +: 8] = 8'(w >> (8 * int'(b % 4)));
      end
    end
    if (e.fault) e.data = '0;
    return e;
  endfunction

  // Monitor: pops an expectation when a response first appears, then checks it holds
  exp_t cur;
  bit   held   = 1'b0;
  bit   cur_ok = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (bus.rsp_valid) begin
      chk("req_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
      if (!held) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          cur_ok = 1'b0;
          $display("FAIL unexpected_rsp: got data %h fault %b, required no response", bus.rsp_data, bus.rsp_fault);
        end else begin
          cur    = q.pop_front();
          cur_ok = 1'b1;
          chk("rsp_data", bus.rsp_data, cur.data);
          chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, cur.fault});
          chk("rsp_latency_cycle", 32'(cyc), 32'(cur.due));
        end
      end else if (cur_ok) begin
        chk("hold_data", bus.rsp_data, cur.data);
        chk("hold_fault", {31'd0, bus.rsp_fault}, {31'd0, cur.fault});
      end
      held = !bus.rsp_ready && !bus.flush;
    end else begin
      held = 1'b0;
      if (q.size() > 0 && cyc > q[0].due) begin
        checks++;
        failures++;
        $display("FAIL rsp_missing: no rsp_valid by cycle %0d, required at %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    model[a]    = d;
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input int hold, input bit flush_end,
                       input bit same_ld, input logic [7:0] la, input logic [31:0] ld);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL req_ready_timeout: req_ready stayed 0, required 1");
    end
    if (same_ld) begin
      bus.ld_en   = 1'b1;
      bus.ld_addr = la;
      bus.ld_data = ld;
      model[la]   = ld;
    end
    bus.rsp_ready = (hold == 0) && !flush_end;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    e     = predict(a);
    e.due = cyc + LAT + ((a[1:0] != 2'd0) ? 1 : 0);
    q.push_back(e);
    tick();
    bus.req_valid = 1'b0;
    bus.ld_en     = 1'b0;
    got = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: rsp_valid stayed 0 for addr %h, required 1", a);
    end
    if (hold > 0 || flush_end) begin
      repeat (hold) @(posedge clk);
      #1;
      if (flush_end) bus.flush = 1'b1;
      else           bus.rsp_ready = 1'b1;
    end
    tick();
    bus.rsp_ready = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    chk("rsp_valid_cleared", {31'd0, bus.rsp_valid}, 32'd0);
    chk("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
    tick();
  endtask

  task automatic expect_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, {31'd0, bus.rsp_valid}, 32'd0);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    logic [31:0] a;
    rst           = 1'b1;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.req_valid = 1'b1;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    chk("reset_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
    chk("reset_ld_err", {31'd0, bus.ld_err}, 32'd0);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(8'(i), $urandom);
    @(negedge clk);
    chk("ld_err_idle", {31'd0, bus.ld_err}, 32'd0);
    tick();

    load(8'd0, 32'h12341233);
    fetch(32'h0, 0, 1'b0, 1'b0, 8'd0, 32'd0);
    load(8'd0, 32'h44332211);
    load(8'd1, 32'h88776655);
    fetch(32'h2, 1, 1'b0, 1'b0, 8'd0, 32'd0);
    fetch(32'h400, 0, 1'b0, 1'b0, 8'd0, 32'd0);
    fetch(32'h3FD, 0, 1'b0, 1'b0, 8'd0, 32'd0);
    fetch(32'h3FC, 2, 1'b0, 1'b0, 8'd0, 32'd0);
    fetch(32'hFFFF_FFFF, 0, 1'b0, 1'b0, 8'd0, 32'd0);

    // Long hold in RESP then flush instead of consuming
    fetch(32'h8, 5, 1'b1, 1'b0, 8'd0, 32'd0);

    // Flush during WAIT drops the fetch; the next one returns normally
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    expect_quiet("flush_wait_no_rsp", LAT + 2);
    fetch(32'h4, 0, 1'b0, 1'b0, 8'd0, 32'd0);

    // Flush in IDLE masks a request
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    @(negedge clk);
    chk("flush_idle_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    expect_quiet("flush_idle_no_rsp", LAT + 2);

    // Load attempted during WAIT is rejected
    begin
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h10;
      e     = predict(32'h10);
      e.due = cyc + LAT;
      q.push_back(e);
      tick();
      bus.req_valid = 1'b0;
      bus.ld_en     = 1'b1;
      bus.ld_addr   = 8'd4;
      bus.ld_data   = ~model[4];
      tick();
      bus.ld_en = 1'b0;
      @(negedge clk);
      chk("ld_err_pulse", {31'd0, bus.ld_err}, 32'd1);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("ld_err_clear", {31'd0, bus.ld_err}, 32'd0);
      tick();
      bus.rsp_ready = 1'b0;
      tick();
    end
    fetch(32'h10, 0, 1'b0, 1'b0, 8'd0, 32'd0);

    // Reset during WAIT discards the request; fetch on the first edge after release
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h1;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_wait_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    fetch(32'h5, 0, 1'b0, 1'b0, 8'd0, 32'd0);

    // Same-cycle load and fetch: the write is visible to the fetch
    fetch(32'h20, 0, 1'b0, 1'b1, 8'd8, 32'hCAFEF00D);
    fetch(32'h23, 1, 1'b0, 1'b1, 8'd9, 32'h0BADBEEF);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = 32'($urandom_range(0, 1023));
      else if (r < 9) a = 32'($urandom_range(1016, 1031));
      else            a = $urandom;
      if ($urandom_range(0, 4) == 0) load(8'($urandom_range(0, 255)), $urandom);
      fetch(a, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0) ? a[9:2] : 8'($urandom_range(0, 255)),
            $urandom);
    end

    repeat (LAT + 3) tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
